// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A and B, then streams skewed operands into an N x N output-stationary PE array.
//   clk, rst_n          clock and asynchronous active-low reset
//   ld_en/ld_sel        buffer write strobe and select (0 = A, 1 = B), accepted only while idle
//   ld_row/ld_col       element index; ld_data element value
//   start               begin a run (ignored while busy)
//   accum               only with FEEDER_ACCUM_EN: skip the clear pulse so products add onto the accumulators
//   busy/done/clear     run in progress, one-cycle completion pulse, array clear
//   a_edge/b_edge       west edge (row i) and north edge (column j), WIDTH bits per lane
module systolic_feeder #(
   parameter int WIDTH = 8,
   parameter int N     = 2,
   localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld_en,
   input  logic               ld_sel,
   input  logic [IW-1:0]      ld_row,
   input  logic [IW-1:0]      ld_col,
   input  logic [WIDTH-1:0]   ld_data,
`ifdef FEEDER_ACCUM_EN
   input  logic               accum,
`endif
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               clear,
   output logic [N*WIDTH-1:0] a_edge,
   output logic [N*WIDTH-1:0] b_edge
);
   localparam int TW = $clog2(3 * N);
   localparam logic [TW-1:0] LAST = TW'(3 * N - 3);
   typedef enum logic [1:0] {IDLE, CLEAR, FEED} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] t_q, t_d;
   logic busy_q, busy_d, done_q, done_d, clear_q, clear_d;
   logic [N*WIDTH-1:0] a_edge_q, a_edge_d, b_edge_q, b_edge_d;
   logic [WIDTH-1:0] abuf_q [N][N];
   logic [WIDTH-1:0] abuf_d [N][N];
   logic [WIDTH-1:0] bbuf_q [N][N];
   logic [WIDTH-1:0] bbuf_d [N][N];
   logic skip_clear;
   int k;
`ifdef FEEDER_ACCUM_EN
   assign skip_clear = accum;
`else
   assign skip_clear = 1'b0;
`endif
   always_comb begin
      abuf_d = abuf_q;
      bbuf_d = bbuf_q;
      if (ld_en && state_q == IDLE) begin
         if (ld_sel) bbuf_d[ld_row][ld_col] = ld_data;
         else abuf_d[ld_row][ld_col] = ld_data;
      end
   end
   always_comb begin
      state_d = state_q;
      t_d = t_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = skip_clear ? FEED : CLEAR;
            t_d = '0;
         end
         CLEAR: begin
            state_d = FEED;
            t_d = '0;
         end
         FEED: if (t_q == LAST) begin
            state_d = IDLE;
            t_d = '0;
            done_d = 1'b1;
         end else t_d = t_q + TW'(1);
         default: state_d = IDLE;
      endcase
   end
   // Outputs are registered, so they are computed from the next state and the post-write buffers;
   // this lets a write in the start cycle reach even the first feed step of an accumulate run.
   always_comb begin
      busy_d = state_d != IDLE;
      clear_d = state_d == CLEAR;
      a_edge_d = '0;
      b_edge_d = '0;
      k = 0;
      if (state_d == FEED)
         for (int i = 0; i < N; i++) begin
            k = int'(t_d) - i;
            if (k >= 0 && k < N) begin
               a_edge_d[i*WIDTH +: WIDTH] = abuf_d[i][IW'(k)];
               b_edge_d[i*WIDTH +: WIDTH] = bbuf_d[IW'(k)][i];
            end
         end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         t_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         clear_q  <= 1'b0;
         a_edge_q <= '0;
         b_edge_q <= '0;
         abuf_q   <= '{default: '0};
         bbuf_q   <= '{default: '0};
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         clear_q  <= clear_d;
         a_edge_q <= a_edge_d;
         b_edge_q <= b_edge_d;
         abuf_q   <= abuf_d;
         bbuf_q   <= bbuf_d;
      end
   assign busy   = busy_q;
   assign done   = done_q;
   assign clear  = clear_q;
   assign a_edge = a_edge_q;
   assign b_edge = b_edge_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed and random checks of systolic_feeder against a run-phase model and a virtual PE array.
module tb_systolic_feeder;
   localparam int W = 8;
   localparam int N = 2;
   localparam int IW = 1;
   localparam int LASTP = 3 * N - 1;
`ifdef FEEDER_ACCUM_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n, ld_en, ld_sel, start, accum_drv;
   logic [IW-1:0] ld_row, ld_col;
   logic [W-1:0] ld_data;
   logic busy, done, clear;
   logic [N*W-1:0] a_edge, b_edge;
   int tests = 0, fails = 0;
   logic [W-1:0] ma [N][N];
   logic [W-1:0] mb [N][N];
   logic [W-1:0] ar [N][N];
   logic [W-1:0] br [N][N];
   logic [W-1:0] ai, bi;
   int mexp [N][N];
   int vc [N][N];
   int p = -1, s, kk;
   bit cvalid, mbusy, macc;
   logic eb, ec, ed;
   logic [N*W-1:0] ea, ebe;
   logic [15:0] ea_lit [4] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
   logic [15:0] eb_lit [4] = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};
   systolic_feeder #(.WIDTH(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col),
      .ld_data(ld_data),
`ifdef FEEDER_ACCUM_EN
      .accum(accum_drv),
`endif
      .start(start), .busy(busy), .done(done), .clear(clear), .a_edge(a_edge), .b_edge(b_edge));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk_c(input int e00, input int e01, input int e10, input int e11);
      chk("C00", 64'(vc[0][0]), 64'(e00));
      chk("C01", 64'(vc[0][1]), 64'(e01));
      chk("C10", 64'(vc[1][0]), 64'(e10));
      chk("C11", 64'(vc[1][1]), 64'(e11));
   endtask
   // Mid-cycle: compare this cycle's outputs with the run phase p, clock the virtual PE array
   // from the edges, then advance the model with the inputs the DUT samples at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         p = -1;
         cvalid = 1'b0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ma[i][j] = '0;
               mb[i][j] = '0;
            end
      end
      eb = p >= 0 && p <= LASTP - 1;
      ec = p == 0;
      ed = p == LASTP;
      ea = '0;
      ebe = '0;
      if (p >= 1 && p <= LASTP - 1)
         for (int i = 0; i < N; i++) begin
            kk = p - 1 - i;
            if (kk >= 0 && kk < N) begin
               ea[i*W +: W] = ma[i][kk];
               ebe[i*W +: W] = mb[kk][i];
            end
         end
      chk("outputs{busy,done,clear,a,b}", 64'({busy, done, clear, a_edge, b_edge}), 64'({eb, ed, ec, ea, ebe}));
      for (int i = N - 1; i >= 0; i--)
         for (int j = N - 1; j >= 0; j--) begin
            ai = (j == 0) ? a_edge[i*W +: W] : ar[i][j-1];
            bi = (i == 0) ? b_edge[j*W +: W] : br[i-1][j];
            vc[i][j] = clear ? 0 : vc[i][j] + int'(ai) * int'(bi);
            ar[i][j] = ai;
            br[i][j] = bi;
         end
      if (ed)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) chk("C_model", 64'(vc[i][j]), 64'(mexp[i][j]));
      if (rst_n) begin
         mbusy = p >= 0 && p < LASTP;
         if (ld_en && !mbusy) begin
            if (ld_sel) mb[ld_row][ld_col] = ld_data;
            else ma[ld_row][ld_col] = ld_data;
         end
         if (start && !mbusy) begin
            macc = accum_drv && ACC_EN;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  s = 0;
                  for (int q = 0; q < N; q++) s += int'(ma[i][q]) * int'(mb[q][j]);
                  mexp[i][j] = (macc ? mexp[i][j] : 0) + s;
               end
            if (!macc) cvalid = 1'b1;
            p = macc ? 1 : 0;
         end else p = mbusy ? p + 1 : -1;
      end
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic load(input logic sel, input int r, input int c, input int d);
      ld_en = 1'b1;
      ld_sel = sel;
      ld_row = IW'(r);
      ld_col = IW'(c);
      ld_data = W'(d);
      step(1);
      ld_en = 1'b0;
   endtask
   task automatic go(input logic acc);
      start = 1'b1;
      accum_drv = acc;
      step(1);
      start = 1'b0;
      accum_drv = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            vc[i][j] = 0;
            mexp[i][j] = 0;
            ar[i][j] = '0;
            br[i][j] = '0;
         end
      {ld_en, ld_sel, start, accum_drv} = '0;
      ld_row = '0;
      ld_col = '0;
      ld_data = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      chk("reset_outputs", 64'({busy, done, clear, a_edge, b_edge}), 64'(0));
      load(0, 0, 0, 1); load(0, 0, 1, 2); load(0, 1, 0, 3); load(0, 1, 1, 4);
      load(1, 0, 0, 5); load(1, 0, 1, 6); load(1, 1, 0, 7); load(1, 1, 1, 8);
      go(0);
      chk("basic_clear_c0", 64'(clear), 64'(1));
      for (int t = 0; t < 4; t++) begin
         step(1);
         chk("basic_a_edge", 64'(a_edge), 64'(ea_lit[t]));
         chk("basic_b_edge", 64'(b_edge), 64'(eb_lit[t]));
      end
      step(1);
      chk("basic_done_c5", 64'(done), 64'(1));
      chk_c(19, 22, 43, 50);
      step(1);
      go(0);
      chk("rerun_clear", 64'(clear), 64'(1));
      step(5);
      chk("rerun_done", 64'(done), 64'(1));
      chk_c(19, 22, 43, 50);
      step(1);
      go(0);
      step(2);
      ld_en = 1'b1; ld_sel = 1'b0; ld_row = '0; ld_col = '0; ld_data = 8'd9; start = 1'b1;
      step(1);
      ld_en = 1'b0;
      start = 1'b0;
      step(2);
      chk("lockout_done", 64'(done), 64'(1));
      chk_c(19, 22, 43, 50);
      step(1);
      chk("lockout_single_done", 64'({busy, done}), 64'(0));
      go(0);
      step(5);
      chk("lockout_rerun_C00", 64'(vc[0][0]), 64'(19));
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("b2b_clear", 64'(clear), 64'(1));
      step(5);
      chk("b2b_done", 64'(done), 64'(1));
      chk_c(19, 22, 43, 50);
      step(1);
`ifdef FEEDER_ACCUM_EN
      go(1);
      chk("accum_no_clear", 64'(clear), 64'(0));
      chk("accum_a_t0", 64'(a_edge), 64'(16'h0001));
      step(4);
      chk("accum_done_c4", 64'(done), 64'(1));
      chk_c(38, 44, 86, 100);
      step(1);
`endif
      go(0);
      step(2);
      rst_n = 1'b0;
      #1;
      chk("reset_midrun", 64'({busy, done, clear, a_edge, b_edge}), 64'(0));
      step(1);
      rst_n = 1'b1;
      go(0);
      step(5);
      chk("post_reset_done", 64'(done), 64'(1));
      chk_c(0, 0, 0, 0);
      step(1);
      for (int c = 0; c < 3000; c++) begin
         ld_en = 1'($urandom_range(0, 1));
         ld_sel = 1'($urandom_range(0, 1));
         ld_row = IW'($urandom_range(0, N - 1));
         ld_col = IW'($urandom_range(0, N - 1));
         ld_data = W'($urandom);
         start = $urandom_range(0, 5) == 0;
         accum_drv = cvalid && ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end else step(1);
      end
      {ld_en, start, accum_drv} = '0;
      step(3 * N + 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
